// File: rtl/prbs_scrambler_stream_pkg.sv
// rtl/prbs_scrambler_stream_pkg.sv - Shared PN polynomial defaults and the multi-bit LFSR step function
package scrambler_pkg;

    localparam int MAX_LFSR_W = 32;
    localparam int MAX_DATA_W = 64;
    localparam int STEP_RES_W = MAX_LFSR_W + MAX_DATA_W;

    // x^15 + x^14 + 1 in the right-shifting Fibonacci form
    localparam logic [14:0] DEFAULT_TAP_MASK = 15'h0003;
    localparam logic [14:0] DEFAULT_SEED     = 15'h4A80;

    // Returns {next_state, out_bits}; state lives in the low w bits, data bit 0 goes first.
    function automatic logic [STEP_RES_W-1:0] lfsr_step_n(
        input logic [MAX_LFSR_W-1:0] state,
        input logic [MAX_DATA_W-1:0] data,
        input logic [MAX_LFSR_W-1:0] mask,
        input int                    n,
        input int                    w
    );
        logic [MAX_LFSR_W-1:0] s;
        logic [MAX_DATA_W-1:0] o;
        logic                  fb;
        s = state;
        o = '0;
        for (int k = 0; k < MAX_DATA_W; k++) begin
            if (k < n) begin
                fb          = ^(s & mask);
                o[6'(k)]    = data[6'(k)] ^ fb;
                s           = s >> 1;
                s[5'(w-1)]  = fb;
            end
        end
        return {s, o};
    endfunction

endpackage

// File: rtl/prbs_scrambler_stream_if.sv
// rtl/prbs_scrambler_stream_if.sv - Valid/ready beat stream with end-of-frame marker
interface prbs_scrambler_stream_if #(
    parameter int DATA_W = 8
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic              last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/prbs_scrambler_stream_lfsr_core.sv
// rtl/prbs_scrambler_stream_lfsr_core.sv - Combinational DATA_W-step LFSR scramble of one beat
module prbs_lfsr_core
    import scrambler_pkg::*;
#(
    parameter int                LFSR_W   = 15,
    parameter logic [LFSR_W-1:0] TAP_MASK = DEFAULT_TAP_MASK,
    parameter int                DATA_W   = 8
) (
    input  logic [LFSR_W-1:0] state_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [LFSR_W-1:0] state_o,
    output logic [DATA_W-1:0] data_o
);
    logic [STEP_RES_W-1:0] step_res;
    logic                  unused_step_bits;

    assign step_res = lfsr_step_n(32'(state_i), 64'(data_i), 32'(TAP_MASK), DATA_W, LFSR_W);
    assign state_o  = step_res[MAX_DATA_W +: LFSR_W];
    assign data_o   = step_res[0 +: DATA_W];
    assign unused_step_bits = ^step_res;
endmodule

// File: rtl/prbs_scrambler_stream.sv
// rtl/prbs_scrambler_stream.sv - Streaming PRBS scrambler/descrambler with handshake, reseed and bypass
module prbs_scrambler_stream
    import scrambler_pkg::*;
#(
    parameter int                LFSR_W   = 15,
    parameter logic [LFSR_W-1:0] TAP_MASK = DEFAULT_TAP_MASK,
    parameter logic [LFSR_W-1:0] SEED     = DEFAULT_SEED,
    parameter int                DATA_W   = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cfg_load_i,
    input  logic [LFSR_W-1:0]       cfg_seed_i,
    input  logic                    cfg_bypass_i,
    input  logic                    cfg_frame_reseed_i,
    prbs_scrambler_stream_if.slave  s_if,
    prbs_scrambler_stream_if.master m_if,
    output logic [LFSR_W-1:0]       lfsr_state_o
);
    logic [LFSR_W-1:0] lfsr_q, lfsr_d, seed_q, seed_d, core_state;
    logic [DATA_W-1:0] m_data_q, m_data_d, core_data;
    logic              m_valid_q, m_valid_d, m_last_q, m_last_d;
    logic              accept;

    prbs_lfsr_core #(
        .LFSR_W   (LFSR_W),
        .TAP_MASK (TAP_MASK),
        .DATA_W   (DATA_W)
    ) u_core (
        .state_i (lfsr_q),
        .data_i  (s_if.data),
        .state_o (core_state),
        .data_o  (core_data)
    );

    assign s_if.ready   = !m_valid_q || m_if.ready;
    assign accept       = s_if.valid && s_if.ready;
    assign m_if.valid   = m_valid_q;
    assign m_if.data    = m_data_q;
    assign m_if.last    = m_last_q;
    assign lfsr_state_o = lfsr_q;

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        lfsr_d    = lfsr_q;
        seed_d    = seed_q;

        if (accept) begin
            m_valid_d = 1'b1;
            m_data_d  = cfg_bypass_i ? s_if.data : core_data;
            m_last_d  = s_if.last;
        end else if (m_if.ready) begin
            m_valid_d = 1'b0;
        end

        // A coincident load still lets the accepted beat use the old state above.
        if (cfg_load_i) begin
            lfsr_d = cfg_seed_i;
            seed_d = cfg_seed_i;
        end else if (accept && cfg_frame_reseed_i && s_if.last) begin
            lfsr_d = seed_q;
        end else if (accept && !cfg_bypass_i) begin
            lfsr_d = core_state;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q    <= SEED;
            seed_q    <= SEED;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
        end else begin
            lfsr_q    <= lfsr_d;
            seed_q    <= seed_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
        end
    end
endmodule

// File: tb/tb_prbs_scrambler_stream.sv
// tb/tb_prbs_scrambler_stream.sv - Directed and randomized checks against a bit-sequence PN model
module tb_prbs_scrambler_stream;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        cfg_load, cfg_bypass, cfg_frame_reseed;
    logic [14:0] cfg_seed, lfsr_state;
    logic        rx_cfg_load;
    logic [14:0] rx_cfg_seed, rx_lfsr_state;

    prbs_scrambler_stream_if #(.DATA_W(8)) s_bus ();
    prbs_scrambler_stream_if #(.DATA_W(8)) m_bus ();
    prbs_scrambler_stream_if #(.DATA_W(8)) rx_s ();
    prbs_scrambler_stream_if #(.DATA_W(8)) rx_m ();

    prbs_scrambler_stream #(.LFSR_W(15), .TAP_MASK(15'h0003), .SEED(15'h4A80), .DATA_W(8)) dut (
        .clk(clk), .reset(reset), .cfg_load_i(cfg_load), .cfg_seed_i(cfg_seed),
        .cfg_bypass_i(cfg_bypass), .cfg_frame_reseed_i(cfg_frame_reseed),
        .s_if(s_bus.slave), .m_if(m_bus.master), .lfsr_state_o(lfsr_state)
    );

    prbs_scrambler_stream #(.LFSR_W(15), .TAP_MASK(15'h0003), .SEED(15'h4A80), .DATA_W(8)) rx (
        .clk(clk), .reset(reset), .cfg_load_i(rx_cfg_load), .cfg_seed_i(rx_cfg_seed),
        .cfg_bypass_i(1'b0), .cfg_frame_reseed_i(1'b0),
        .s_if(rx_s.slave), .m_if(rx_m.master), .lfsr_state_o(rx_lfsr_state)
    );

    int passes = 0;
    int checks = 0;
    int fails  = 0;

    // Reference: the generator is a window over a PN bit sequence x, where
    // x[t+15] = XOR of x[t+i] over the tap set and the keystream bit is x[t+15].
    bit          win[$];
    logic [14:0] taps_m = 15'h0003;
    logic [14:0] seed_m;
    logic [8:0]  q[$];

    function automatic void m_seed(input logic [14:0] s);
        win.delete();
        for (int i = 0; i < 15; i++) win.push_back(s[i]);
    endfunction

    function automatic logic [7:0] m_scramble(input logic [7:0] d);
        logic [7:0] r;
        bit         fb;
        for (int k = 0; k < 8; k++) begin
            fb = 1'b0;
            for (int i = 0; i < 15; i++) if (taps_m[i]) fb ^= win[i];
            r[k] = d[k] ^ fb;
            void'(win.pop_front());
            win.push_back(fb);
        end
        return r;
    endfunction

    function automatic logic [14:0] m_state();
        logic [14:0] r;
        for (int i = 0; i < 15; i++) r[i] = win[i];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Samples at the falling edge, updates the model, then returns 1 time unit after the rising edge.
    task automatic tick();
        logic [8:0] e;
        logic       acc;
        @(negedge clk);
        check("m_valid", 32'(m_bus.valid), 32'(q.size() != 0));
        check("s_ready", 32'(s_bus.ready), 32'((q.size() == 0) || m_bus.ready));
        if (q.size() != 0) check("m_beat", 32'({m_bus.last, m_bus.data}), 32'(q[0]));
        acc = s_bus.valid && ((q.size() == 0) || m_bus.ready);
        if (q.size() != 0 && m_bus.ready) void'(q.pop_front());
        if (acc) begin
            e[8]   = s_bus.last;
            e[7:0] = cfg_bypass ? s_bus.data : m_scramble(s_bus.data);
            q.push_back(e);
        end
        if (cfg_load) begin
            seed_m = cfg_seed;
            m_seed(cfg_seed);
        end else if (acc && cfg_frame_reseed && s_bus.last) begin
            m_seed(seed_m);
        end
        @(posedge clk);
        #1;
        check("lfsr_state", 32'(lfsr_state), 32'(m_state()));
    endtask

    logic [7:0]  rec [3];
    logic [7:0]  frame [3];
    logic [14:0] held;

    initial begin
        cfg_load = 0; cfg_bypass = 0; cfg_frame_reseed = 0; cfg_seed = '0;
        rx_cfg_load = 0; rx_cfg_seed = '0;
        s_bus.valid = 0; s_bus.data = '0; s_bus.last = 0; m_bus.ready = 1;
        rx_s.valid = 0; rx_s.data = '0; rx_s.last = 0; rx_m.ready = 1;
        seed_m = 15'h4A80;
        m_seed(15'h4A80);

        @(posedge clk); @(posedge clk); #1;
        check("rst_m_valid", 32'(m_bus.valid), 32'(0));
        check("rst_m_data", 32'(m_bus.data), 32'(0));
        check("rst_m_last", 32'(m_bus.last), 32'(0));
        check("rst_lfsr", 32'(lfsr_state), 32'(15'h4A80));
        reset = 0;
        #1;
        check("rst_s_ready", 32'(s_bus.ready), 32'(1));

        // Known-answer from seed 1 with zero data
        cfg_load = 1; cfg_seed = 15'h0001; tick(); cfg_load = 0;
        s_bus.valid = 1; s_bus.data = 8'h00;
        tick();
        check("kat_data0", 32'(m_bus.data), 32'(8'h01));
        check("kat_lfsr0", 32'(lfsr_state), 32'(15'h0080));
        tick();
        check("kat_data1", 32'(m_bus.data), 32'(8'hC0));
        check("kat_lfsr1", 32'(lfsr_state), 32'(15'h6000));
        s_bus.valid = 0; tick();

        // Round trip through a second instance
        cfg_load = 1; cfg_seed = 15'h0001; rx_cfg_load = 1; rx_cfg_seed = 15'h0001;
        tick();
        cfg_load = 0; rx_cfg_load = 0;
        s_bus.valid = 1; s_bus.data = 8'hFF; rx_s.valid = 1; rx_s.data = 8'hFE;
        tick();
        check("tx_ff", 32'(m_bus.data), 32'(8'hFE));
        check("rx_fe", 32'(rx_m.data), 32'(8'hFF));
        check("rx_lfsr", 32'(rx_lfsr_state), 32'(15'h0080));
        check("rx_ready", 32'(rx_s.ready), 32'(1));
        check("rx_last", 32'(rx_m.last), 32'(0));
        s_bus.valid = 0; rx_s.valid = 0; tick();

        // Frame-synchronous reseed reproduces the frame
        cfg_frame_reseed = 1; cfg_load = 1; cfg_seed = 15'h1234; tick(); cfg_load = 0;
        for (int i = 0; i < 3; i++) frame[i] = 8'($urandom);
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 3; i++) begin
                s_bus.valid = 1; s_bus.data = frame[i]; s_bus.last = (i == 2);
                tick();
                if (f == 0) rec[i] = m_bus.data;
                else check("reseed_repeat", 32'(m_bus.data), 32'(rec[i]));
            end
            check("reseed_lfsr", 32'(lfsr_state), 32'(15'h1234));
        end
        s_bus.valid = 0; s_bus.last = 0; cfg_frame_reseed = 0; tick();

        // Backpressure: one buffered beat, then held
        s_bus.valid = 1; s_bus.data = 8'h11; tick();
        m_bus.ready = 0; s_bus.data = 8'h22;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_ready", 32'(s_bus.ready), 32'(0));
        end
        m_bus.ready = 1; tick();
        s_bus.valid = 0; tick(); tick();

        // Bypass
        held = lfsr_state;
        cfg_bypass = 1; s_bus.valid = 1;
        s_bus.data = 8'hA5; tick();
        check("byp_a5", 32'(m_bus.data), 32'(8'hA5));
        s_bus.data = 8'h3C; tick();
        check("byp_3c", 32'(m_bus.data), 32'(8'h3C));
        check("byp_lfsr", 32'(lfsr_state), 32'(held));
        cfg_bypass = 0;

        // Load coincident with an accepted beat
        cfg_load = 1; cfg_seed = 15'h0ABC; s_bus.data = 8'h55; tick();
        cfg_load = 0;
        check("load_beat_lfsr", 32'(lfsr_state), 32'(15'h0ABC));

        // All-zero seed passes data through
        cfg_load = 1; cfg_seed = 15'h0000; s_bus.valid = 0; tick(); cfg_load = 0;
        s_bus.valid = 1; s_bus.data = 8'h5A; tick();
        check("zero_seed_data", 32'(m_bus.data), 32'(8'h5A));
        check("zero_seed_lfsr", 32'(lfsr_state), 32'(0));

        for (int i = 0; i < 300; i++) begin
            s_bus.valid      = ($urandom_range(3) != 0);
            s_bus.data       = 8'($urandom);
            s_bus.last       = ($urandom_range(3) == 0);
            m_bus.ready      = ($urandom_range(3) != 0);
            cfg_bypass       = ($urandom_range(7) == 0);
            cfg_frame_reseed = (i >= 150);
            cfg_load         = ($urandom_range(31) == 0);
            cfg_seed         = 15'($urandom);
            tick();
        end
        cfg_load = 0; cfg_bypass = 0; cfg_frame_reseed = 0;

        // Asynchronous reset with a beat in flight
        s_bus.valid = 1; s_bus.last = 0; m_bus.ready = 0; s_bus.data = 8'h77;
        tick();
        check("pre_rst_valid", 32'(m_bus.valid), 32'(1));
        s_bus.valid = 0;
        reset = 1;
        #1;
        check("async_rst_valid", 32'(m_bus.valid), 32'(0));
        check("async_rst_lfsr", 32'(lfsr_state), 32'(15'h4A80));
        q.delete();
        seed_m = 15'h4A80;
        m_seed(15'h4A80);
        #3 reset = 0;
        m_bus.ready = 1;
        tick();
        check("post_rst_lfsr", 32'(lfsr_state), 32'(15'h4A80));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
